// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD registered read ports,
// optional zero register, write-to-read forwarding and a sequential clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     clr_req,
    output logic                     busy
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_next;
    logic                w_busy;
    logic                w_wv0;
    logic                w_wv1;
    logic [DATA_W-1:0]   w_regs [NUM_REGS];

    // An address is usable if it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_busy = (r_state == S_CLEAR);
    assign busy   = w_busy;
    assign w_wv0  = we0 && !w_busy && addr_ok(waddr0);
    assign w_wv1  = we1 && !w_busy && addr_ok(waddr1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_next = S_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            S_CLEAR: begin
                if (r_ptr == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_next = S_IDLE;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    // Storage: port 1 is checked first so it wins a same-address collision.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_busy && (r_ptr == ADDR_W'(gi))) begin
                r_q <= '0;
            end else if (w_wv1 && (waddr1 == ADDR_W'(gi))) begin
                r_q <= wdata1;
            end else if (w_wv0 && (waddr0 == ADDR_W'(gi))) begin
                r_q <= wdata0;
            end
        end
        assign w_regs[gi] = r_q;
    end

    // Read ports; forwarding never applies to the clear (writes are off while busy).
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_val;
        logic [DATA_W-1:0] r_rd_data;

        assign w_ra = rd_addr[gi*ADDR_W +: ADDR_W];

        always_comb begin
            w_val = '0;
            if (addr_ok(w_ra)) begin
                w_val = w_regs[w_ra];
                if (BYPASS != 0) begin
                    if (w_wv1 && (waddr1 == w_ra)) begin
                        w_val = wdata1;
                    end else if (w_wv0 && (waddr0 == w_ra)) begin
                        w_val = wdata0;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data <= '0;
            end else begin
                r_rd_data <= w_val;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = r_rd_data;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count (>=2); ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-005 Parameter BYPASS, default 1, write-to-read forwarding when 1.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NUM_RD*DATA_W  registered read data, port i at bits [i*DATA_W +: DATA_W].
REQ-010 we0 / waddr0 / wdata0  input  1 / ADDR_W / DATA_W  write port 0.
REQ-011 we1 / waddr1 / wdata1  input  1 / ADDR_W / DATA_W  write port 1.
REQ-012 clr_req  input  1  request sequential clear of all registers.
REQ-013 busy  output  1  high while clear sweep in progress.

Function
REQ-014 Write: at rising edge, weN=1 stores wdataN into register waddrN; both ports may write different registers in the same cycle.
REQ-015 Same-address collision (we0=we1=1, waddr0==waddr1): port 1 value stored, port 0 discarded.
REQ-016 Writes to address >= NUM_REGS ignored; writes to address 0 ignored when ZERO_REG=1.
REQ-017 Read latency 1 cycle: rd_data port i at edge k reflects rd_addr port i sampled at edge k.
REQ-018 BYPASS=1: read of address written at the same edge returns the new value (port 1 priority per REQ-015); BYPASS=0: returns pre-write value.
REQ-019 Read of address 0 with ZERO_REG=1, or address >= NUM_REGS, returns 0.
REQ-020 FSM states IDLE and CLEAR; clr_req=1 sampled in IDLE -> CLEAR with sweep pointer 0.
REQ-021 In CLEAR, each edge zeroes register[ptr] and increments ptr; edge with ptr==NUM_REGS-1 returns to IDLE.
REQ-022 busy=1 exactly in CLEAR: asserted the cycle after clr_req sampled, held NUM_REGS cycles.
REQ-023 clr_req while busy=1 ignored (no restart, no queuing).
REQ-024 we0/we1 ignored while busy=1, including the edge that leaves CLEAR.
REQ-025 Reads during CLEAR return current contents; register[ptr] read on its clearing edge returns the pre-clear value, no bypass of the clear.
REQ-026 clr_req and weN high in the same IDLE cycle: write performed, clear starts next cycle and later zeroes it.

Reset
REQ-027 rst=1 asynchronously zeroes all registers, all rd_data lanes, busy, ptr; FSM -> IDLE.
REQ-028 rst asserted mid-sweep aborts the clear; after release, block is IDLE with all registers 0.
REQ-029 First write accepted on the first rising edge with rst=0.

Verification
REQ-030 Defaults: we0 waddr0=5 wdata0=0xDEADBEEF; next edge rd_addr0=5 -> one edge later rd_data0=0xDEADBEEF.
REQ-031 Collision: we0=we1=1, both addr 7, wdata0=0x11, wdata1=0x22, rd_addr1=7 same cycle, BYPASS=1 -> rd_data1=0x22 after the edge; BYPASS=0 build -> previous value (0).
REQ-032 Zero reg: write 0xFFFFFFFF to addr 0 -> read addr 0 returns 0; ZERO_REG=0 build returns 0xFFFFFFFF.
REQ-033 Clear: fill regs 1..31 with index value, pulse clr_req one cycle -> busy high exactly 32 cycles; writes (addr 3, 0xAA) during busy dropped; afterwards all reads 0.
REQ-034 Reset mid-sweep at ptr=10 -> busy=0 and rd_data=0 immediately, all registers read 0, new clr_req restarts sweep from ptr 0.
REQ-035 Parameter sweep: DATA_W=16, NUM_REGS=8, NUM_RD=4 -> four simultaneous reads of distinct registers each return correct value one cycle later; write to addr 9 out of range impossible (ADDR_W=3) and addr 7 read returns last write.
